// File: rtl/icache_refill_arbiter.sv
// rtl/icache_refill_arbiter.sv - I-cache refill source selector: prefetch buffer hit or own AXI INCR burst
// Streams one word per cycle into the I-cache write port and counts buffer- vs AXI-served misses.
module icache_refill_arbiter #(
  parameter int         LINE_WORDS = 16,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req,
  input  logic [31:0]                  miss_addr,
  input  logic [31:0]                  pf_addr,
  input  logic [LINE_WORDS-1:0][31:0]  pf_data,
  input  logic                         pf_ready,
  input  logic                         pf_busy,
  output logic                         refill_valid,
  output logic [3:0]                   refill_idx,
  output logic [31:0]                  refill_data,
  output logic                         refill_last,
  output logic                         refill_done,
  output logic [15:0]                  hit_cnt,
  output logic [15:0]                  miss_cnt,
  output logic [3:0]                   arid,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic                         arvalid,
  input  logic                         arready,
  input  logic [3:0]                   rid,
  input  logic [31:0]                  rdata,
  input  logic [1:0]                   rresp,
  input  logic                         rlast,
  input  logic                         rvalid,
  output logic                         rready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT_PF = 3'd1;
  localparam logic [2:0] S_BUF     = 3'd2;
  localparam logic [2:0] S_AR      = 3'd3;
  localparam logic [2:0] S_R       = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [3:0] LAST_IDX = 4'(LINE_WORDS - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] la_q, la_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] miss_la;
  logic        pf_match;

  // The interconnect routes by id and errors are not reported upstream.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, miss_addr[5:0]};

  assign miss_la  = {miss_addr[31:6], 6'b0};
  assign pf_match = (pf_addr == miss_la);

  always_comb begin
    state_d    = state_q;
    la_d       = la_q;
    cnt_d      = cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          la_d  = miss_la;
          cnt_d = '0;
          if (pf_ready && pf_match) begin
            state_d   = S_BUF;
            hit_cnt_d = hit_cnt_q + 16'd1;
          end else if (pf_busy && pf_match) begin
            state_d = S_WAIT_PF;
          end else begin
            state_d    = S_AR;
            miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      S_WAIT_PF: begin
        if (pf_ready) begin
          state_d   = S_BUF;
          hit_cnt_d = hit_cnt_q + 16'd1;
        end else if (!pf_busy) begin
          state_d    = S_AR;
          miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      S_BUF: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_IDX) state_d = S_DONE;
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        // rlast ends the line even if the beat count disagrees.
        if (rvalid) begin
          cnt_d = cnt_q + 4'd1;
          if (rlast) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      la_q       <= '0;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      la_q       <= la_d;
      cnt_q      <= cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    refill_valid = 1'b0;
    refill_idx   = '0;
    refill_data  = '0;
    refill_last  = 1'b0;
    refill_done  = 1'b0;
    arid         = '0;
    araddr       = '0;
    arlen        = '0;
    arsize       = '0;
    arburst      = '0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (state_q)
      S_BUF: begin
        refill_valid = 1'b1;
        refill_idx   = cnt_q;
        refill_data  = pf_data[cnt_q];
        refill_last  = (cnt_q == LAST_IDX);
      end
      S_AR: begin
        arvalid = 1'b1;
        araddr  = la_q;
        arid    = AXI_ID;
        arlen   = 8'(LINE_WORDS - 1);
        arsize  = 3'd2;
        arburst = 2'b01;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          refill_valid = 1'b1;
          refill_idx   = cnt_q;
          refill_data  = rdata;
          refill_last  = rlast;
        end
      end
      S_DONE:  refill_done = 1'b1;
      default: ;
    endcase
  end

endmodule
